// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Optional MADD accumulate (op 6) is enabled by defining MDU_MADD_EN.
`timescale 1ns/1ps
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_out
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OpMadd  = 3'd6;
`endif

  logic            r_busy;
  logic [CntW-1:0] r_cnt;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [2:0]      r_op;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_b_nz;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quo_u;
  logic [31:0] w_rem_u;
  logic [63:0] w_res;

  // Low 64 bits of the sign-extended product equal the exact signed product.
  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
  assign w_b_nz  = (r_b != 32'd0);
  assign w_a_mag = r_a[31] ? (32'd0 - r_a) : r_a;
  assign w_b_mag = r_b[31] ? (32'd0 - r_b) : r_b;
  assign w_q_mag = w_b_nz ? (w_a_mag / w_b_mag) : 32'd0;
  assign w_r_mag = w_b_nz ? (w_a_mag % w_b_mag) : 32'd0;
  assign w_quo_s = (r_a[31] ^ r_b[31]) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem_s = r_a[31] ? (32'd0 - w_r_mag) : w_r_mag;
  assign w_quo_u = w_b_nz ? (r_a / r_b) : 32'd0;
  assign w_rem_u = w_b_nz ? (r_a % r_b) : 32'd0;

  always_comb begin
    w_res = {r_hi, r_lo};
    case (r_op)
      OpMult:  w_res = w_prod_s;
      OpMultu: w_res = w_prod_u;
      OpDiv:   if (w_b_nz) w_res = {w_rem_s, w_quo_s};
      OpDivu:  if (w_b_nz) w_res = {w_rem_u, w_quo_u};
`ifdef MDU_MADD_EN
      OpMadd:  w_res = {r_hi, r_lo} + w_prod_s;
`endif
      default: w_res = {r_hi, r_lo};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_a    <= 32'd0;
      r_b    <= 32'd0;
      r_op   <= 3'd0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - CntW'(1);
      if (r_cnt == CntW'(1)) begin
        r_busy       <= 1'b0;
        {r_hi, r_lo} <= w_res;
      end
    end else if (start) begin
      case (op)
`ifdef MDU_MADD_EN
        OpMult, OpMultu, OpMadd: begin
`else
        OpMult, OpMultu: begin
`endif
          r_busy <= 1'b1;
          r_cnt  <= CntW'(MULT_CYCLES);
          r_a    <= A;
          r_b    <= B;
          r_op   <= op;
        end
        OpDiv, OpDivu: begin
          r_busy <= 1'b1;
          r_cnt  <= CntW'(DIV_CYCLES);
          r_a    <= A;
          r_b    <= B;
          r_op   <= op;
        end
        OpMthi:  r_hi <= A;
        OpMtlo:  r_lo <= A;
        default: ;
      endcase
    end
  end

  assign busy   = r_busy;
  assign HI     = r_hi;
  assign LO     = r_lo;
  assign MD_out = rd_sel ? r_hi : r_lo;

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the P6 pipelined MIPS core.
- Sits beside the combinational ALU in the EX stage.
- The ALU produces a 32-bit result in the same cycle; this block accepts operands with a start pulse, holds busy for a fixed latency, then commits a 64-bit result to HI/LO.
- The stall unit reads busy/start to freeze mult/div and mf/mt instructions in ID.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD when enabled); legal range >= 1.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  issue strobe for the operation on op, sampled at rising edge.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD (optional), 7 reserved.
- A  input  32  rs operand (multiplicand/dividend, or MTHI/MTLO data).
- B  input  32  rt operand (multiplier/divisor).
- rd_sel  input  1  read select: 0 = LO, 1 = HI.
- busy  output  1  high while an operation is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.
- MD_out  output  32  combinational: rd_sel ? HI : LO (MFHI/MFLO path).

Behaviour:
- Reset:
  - When reset is 0, asynchronously clear busy, HI, LO, the counter, and the latched operands/op to 0.
  - MD_out therefore reads 0.
- Idle (busy=0) with start=1 at edge t:
  - op 0–3: latch A, B and op; load counter with N (MULT_CYCLES or DIV_CYCLES); busy=1 from t onward.
  - op 4 (MTHI): HI<=A at edge t; busy stays 0.
  - op 5 (MTLO): LO<=A at edge t; busy stays 0.
  - op 7, or op 6 with the feature disabled: no effect.
- Counting: each edge while busy decrements the counter. At the edge where the counter goes 1->0:
  - HI/LO are written.
  - busy falls at that same edge.
  - Net effect: busy is high for exactly N cycles after issue, and new HI/LO are visible in the first cycle busy=0.
- start while busy=1: ignored for every op, including MTHI/MTLO; HI/LO are unchanged by it. The pipeline must stall instead.
- Back-to-back: start is accepted in the first cycle busy=0, i.e. the edge right after commit.
- Operands are latched at issue. Changes on A/B during busy have no effect.
- Results are computed from the latched operands:
  - MULT: {HI,LO} = signed A * signed B (64-bit).
  - MULTU: {HI,LO} = unsigned product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. Special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient to LO, remainder to HI.
  - Divide by zero (B=0, DIV or DIVU): full latency is still taken; HI and LO are left unchanged at commit.
- During busy, HI, LO and MD_out show the old values. Consumers must stall on busy.
- Reset asserted mid-operation: the operation is aborted, busy=0, HI=LO=0 immediately, and no commit occurs after release.
- All arithmetic is exact 64-bit; no saturation or flags.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 6 (MADD) is legal.
  - {HI,LO} <= {HI,LO} + signed A * signed B, computed as 64-bit modulo 2^64.
  - Uses MULT_CYCLES latency.
  - The accumulator base is the HI/LO value present at commit.
- Undefined:
  - op 6 behaves like op 7: start is ignored, busy stays 0, no state change.
  - No accumulate adder is synthesised.

Test Plan:
- Reset then MTLO A=0x12345678, rd_sel=0 -> LO=0x12345678 next cycle, busy never rises, MD_out=0x12345678.
- MULT A=0xFFFFFFFE(-2), B=3 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. The same operands with MULTU give HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9(-7), B=2 -> busy 10 cycles, LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). DIVU A=7, B=2 gives LO=3, HI=1.
- DIV with B=0 after HI=5, LO=9 -> busy 10 cycles, HI=5, LO=9 unchanged. DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- MULT issued, then start with MTHI A=0xDEAD during busy -> MTHI is ignored and the product commits. Asserting reset at busy cycle 3 clears busy/HI/LO, and no later commit occurs.
- MDU_MADD_EN defined: HI=0, LO=0xFFFFFFFF, MADD A=1, B=1 -> after 5 cycles HI=1, LO=0. Undefined: the same stimulus leaves busy=0 and HI/LO unchanged.
